timebase: RTL and testbench
===========================

# timebase

Parametrised system timebase: divides `sys_clk` into a one-cycle `tick` strobe at `TICK_HZ` and keeps a free-running tick counter with wrap indication. It also provides `NUM_CH` independent countdown timer channels (one-shot or periodic) clocked by that strobe. It sits beside the CPU/peripheral logic as the single source of millisecond-style time. It generates no derived clocks; all state runs on `sys_clk`.

## Interface
- `CLK_HZ`, 50_000_000: `sys_clk` frequency.
- `TICK_HZ`, 1000: tick rate. `DIV = CLK_HZ/TICK_HZ`, must be ≥ 2 (elaboration error otherwise).
- `CNT_W`, 32: width of `ticks`.
- `PER_W`, 16: width of each channel period.
- `NUM_CH`, 2: number of timer channels, ≥ 1.

Ports (reset values in the Operation section):
- `sys_clk` in 1: system clock.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `en` in 1: tick enable. Low freezes the prescaler, `ticks`, and all channels.
- `clr` in 1: synchronous clear of the prescaler, `ticks`, and all channels.
- `tick` out 1: one-cycle strobe every `DIV` enabled cycles.
- `ticks` out CNT_W: number of ticks since reset or `clr`.
- `ticks_wrap` out 1: one-cycle pulse when `ticks` wraps to 0.
- `ch_load` in NUM_CH: per-channel load/start strobe.
- `ch_stop` in NUM_CH: per-channel abort strobe.
- `ch_periodic` in NUM_CH: mode, sampled at load.
- `ch_period` in NUM_CH*PER_W: period in ticks. Channel i uses bits `[i*PER_W +: PER_W]`.
- `ch_busy` out NUM_CH: channel in RUN.
- `ch_expire` out NUM_CH: one-cycle expiry pulse.

## Operation
**Reset.** While `sys_rst_n` is low:
- prescaler = 0, `tick` = 0, `ticks` = 0, `ticks_wrap` = 0
- all channels IDLE, `ch_busy` = 0, `ch_expire` = 0

**Prescaler.** Counts 0..DIV-1 on cycles with `en` = 1. On the edge where it holds DIV-1 and `en` = 1:
- it returns to 0
- `tick` is registered high for one cycle
- `ticks` increments on the same edge

**Wrap.** On the increment from all-ones, `ticks` becomes 0 and `ticks_wrap` pulses with `tick`.

**Clear.** `clr` takes priority over `en`. On a `clr` edge:
- prescaler = 0, `ticks` = 0
- `tick` and `ticks_wrap` low the next cycle
- all channels go to IDLE with no expire

**Channel FSM** (per channel; each channel holds `remain[PER_W]`, `reload[PER_W]` and `mode`):
- **IDLE, `ch_load`, P ≠ 0:** `remain` = P, `reload` = P, `mode` = `ch_periodic`, go to RUN.
- **IDLE, `ch_load`, P = 0:** `ch_expire` pulses next cycle; stay IDLE.
- **RUN, `ch_load`:** restart with the new P and mode. A pending expiry in that cycle is discarded.
- **RUN, `ch_stop`:** go to IDLE with no expire. `ch_load` and `ch_stop` in the same cycle: load wins.
- **RUN, `tick` high, `remain` > 1:** `remain` decrements.
- **RUN, `tick` high, `remain` = 1:** `ch_expire` pulses. Periodic: `remain` = `reload`, stay in RUN. One-shot: go to IDLE.
- `ch_busy` = (state == RUN).
- Channels are independent. Several channels may expire on the same cycle.

## Timing
- With `en` held high, the first `tick` is high in cycle DIV after reset release (cycles counted from 1). Subsequent ticks follow every DIV cycles, exactly; no half-period skew.
- `tick`, `ticks`, and `ticks_wrap` change on the same edge.
- Channels sample the registered `tick`. `ch_expire` rises one cycle after the `tick` cycle that consumed the final count.
- Load latency: `ch_busy` is high the cycle after `ch_load`.
- Expiry timing: `ch_expire` occurs after P ticks, so 1..DIV cycles of phase uncertainty relative to the load.
- A load on the same cycle `tick` is high does not count that tick.
- `en` low mid-period holds the prescaler phase. Resuming continues from the held phase; it does not restart the period.
- Asynchronous reset mid-operation aborts everything immediately. No expire is produced.

## Configuration
- `TIMEBASE_PERIODIC_EN` defined: periodic mode operates as described above.
- Undefined: `ch_periodic` is ignored and the `reload` registers are not built. Every channel is one-shot and returns to IDLE on expiry.

## Structure
- Package `timebase_pkg`:
  - `ch_state_t` enum {IDLE, RUN}
  - function `calc_div(CLK_HZ, TICK_HZ)`
- Sub-module `timebase_channel`: one FSM, generated `NUM_CH` times. The top level holds the prescaler, the tick counter, and the generate loop.

## Test plan
Unless stated otherwise, the bench runs with CLK_HZ=1000, TICK_HZ=100 (DIV=10), CNT_W=4, PER_W=8, NUM_CH=2.
1. Release reset with `en` = 1 → first `tick` in cycle 10. 16 ticks → `ticks` 15→0 with `ticks_wrap` high on that cycle.
2. Drop `en` for 7 cycles mid-period → next `tick` is delayed by exactly 7 cycles. `clr` at `ticks` = 5 → `ticks` = 0 and the next `tick` comes 10 cycles later.
3. Load ch0 one-shot with P = 3 → `ch_expire[0]` one cycle after the 3rd tick, then `ch_busy[0]` = 0.
4. Load ch1 periodic with P = 2 → `ch_expire[1]` after every 2nd tick. Run 5 periods, then `ch_stop` → no further expires.
5. Load with P = 0 → expire next cycle and `busy` never high. Reload at `remain` = 1 on the same cycle as `tick` → no expire, and the countdown restarts.
6. Assert reset mid-count → all outputs 0 immediately. Build without `TIMEBASE_PERIODIC_EN` → a periodic load behaves as one-shot.

Source files
------------

// File: rtl/timebase_pkg.sv
// timebase_pkg: shared types and helpers for the system timebase.
// Channel FSM state encoding and the prescaler divide calculation.
package timebase_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  function automatic int unsigned calc_div(
    input int unsigned clk_hz,
    input int unsigned tick_hz
  );
    if (tick_hz == 0) begin
      return 0;
    end
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/timebase_channel.sv
// timebase_channel: one countdown timer clocked by the timebase tick strobe.
// Periodic reload is built only when TIMEBASE_PERIODIC_EN is defined.
module timebase_channel
  import timebase_pkg::*;
#(
  parameter int unsigned PER_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic             stop_i,
  input  logic             periodic_i,
  input  logic [PER_W-1:0] period_i,
  output logic             busy_o,
  output logic             expire_o
);

  localparam logic [PER_W-1:0] ONE = PER_W'(1);

  ch_state_t        state_q, state_d;
  logic [PER_W-1:0] remain_q, remain_d;
  logic             expire_q, expire_d;

`ifdef TIMEBASE_PERIODIC_EN
  logic [PER_W-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
`else
  logic             unused_periodic;
  assign unused_periodic = periodic_i;
`endif

  // Next state: clear, then load (wins over stop and expiry), then countdown.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    expire_d = 1'b0;
`ifdef TIMEBASE_PERIODIC_EN
    reload_d = reload_q;
    mode_d   = mode_q;
`endif
    if (clr_i) begin
      state_d = IDLE;
    end else if (load_i) begin
      if (period_i != '0) begin
        state_d  = RUN;
        remain_d = period_i;
`ifdef TIMEBASE_PERIODIC_EN
        reload_d = period_i;
        mode_d   = periodic_i;
`endif
      end else begin
        state_d  = IDLE;
        expire_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      if (stop_i) begin
        state_d = IDLE;
      end else if (tick_i) begin
        if (remain_q > ONE) begin
          remain_d = remain_q - ONE;
        end else begin
          expire_d = 1'b1;
`ifdef TIMEBASE_PERIODIC_EN
          if (mode_q) begin
            remain_d = reload_q;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      remain_q <= '0;
      expire_q <= 1'b0;
`ifdef TIMEBASE_PERIODIC_EN
      reload_q <= '0;
      mode_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      expire_q <= expire_d;
`ifdef TIMEBASE_PERIODIC_EN
      reload_q <= reload_d;
      mode_q   <= mode_d;
`endif
    end
  end

  assign busy_o   = (state_q == RUN);
  assign expire_o = expire_q;

endmodule

// File: rtl/timebase.sv
// timebase: prescaler, free-running tick counter and NUM_CH timer channels.
// Optional periodic channel mode: define TIMEBASE_PERIODIC_EN.
module timebase
  import timebase_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PER_W   = 16,
  parameter int unsigned NUM_CH  = 2
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    en,
  input  logic                    clr,
  output logic                    tick,
  output logic [CNT_W-1:0]        ticks,
  output logic                    ticks_wrap,
  input  logic [NUM_CH-1:0]       ch_load,
  input  logic [NUM_CH-1:0]       ch_stop,
  input  logic [NUM_CH-1:0]       ch_periodic,
  input  logic [NUM_CH*PER_W-1:0] ch_period,
  output logic [NUM_CH-1:0]       ch_busy,
  output logic [NUM_CH-1:0]       ch_expire
);

  localparam int unsigned DIV  = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PS_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("timebase: CLK_HZ/TICK_HZ must be at least 2");
  end

  if (NUM_CH < 1) begin : g_ch_chk
    $error("timebase: NUM_CH must be at least 1");
  end

  logic [PS_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0] ticks_q, ticks_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  // Prescaler and tick counter; clr beats en, en low holds the phase.
  always_comb begin
    presc_d = presc_q;
    ticks_d = ticks_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (clr) begin
      presc_d = '0;
      ticks_d = '0;
    end else if (en) begin
      if (presc_q == PS_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
        ticks_d = ticks_q + 1'b1;
        wrap_d  = &ticks_q;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Timebase registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_q <= '0;
      ticks_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      ticks_q <= ticks_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign tick       = tick_q;
  assign ticks      = ticks_q;
  assign ticks_wrap = wrap_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timebase_channel #(
      .PER_W (PER_W)
    ) u_ch (
      .clk        (sys_clk),
      .rst_n      (sys_rst_n),
      .clr_i      (clr),
      .tick_i     (tick_q),
      .load_i     (ch_load[i]),
      .stop_i     (ch_stop[i]),
      .periodic_i (ch_periodic[i]),
      .period_i   (ch_period[i*PER_W +: PER_W]),
      .busy_o     (ch_busy[i]),
      .expire_o   (ch_expire[i])
    );
  end

endmodule

// File: tb/tb_timebase.sv
// tb_timebase: directed self-checking bench for timebase.
// DIV=10, CNT_W=4, PER_W=8, NUM_CH=2.
module tb_timebase;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        en;
  logic        clr;
  logic        tick;
  logic [3:0]  ticks;
  logic        ticks_wrap;
  logic [1:0]  ch_load;
  logic [1:0]  ch_stop;
  logic [1:0]  ch_periodic;
  logic [15:0] ch_period;
  logic [1:0]  ch_busy;
  logic [1:0]  ch_expire;

  int nerr = 0;
  int nchk = 0;

  timebase #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .CNT_W   (4),
    .PER_W   (8),
    .NUM_CH  (2)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .en          (en),
    .clr         (clr),
    .tick        (tick),
    .ticks       (ticks),
    .ticks_wrap  (ticks_wrap),
    .ch_load     (ch_load),
    .ch_stop     (ch_stop),
    .ch_periodic (ch_periodic),
    .ch_period   (ch_period),
    .ch_busy     (ch_busy),
    .ch_expire   (ch_expire)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    en          = 1'b1;
    clr         = 1'b0;
    ch_load     = '0;
    ch_stop     = '0;
    ch_periodic = '0;
    ch_period   = '0;

    step(2);
    check("rst_tick", tick, 0);
    check("rst_ticks", ticks, 0);
    check("rst_wrap", ticks_wrap, 0);
    check("rst_busy", ch_busy, 0);
    check("rst_expire", ch_expire, 0);

    // first tick after 10 enabled edges
    sys_rst_n = 1'b1;
    step(9);
    check("tick_pre10", tick, 0);
    step(1);
    check("tick_at10", tick, 1);
    check("ticks_1", ticks, 1);
    repeat (14) step(10);
    check("ticks_15", ticks, 15);
    check("wrap_pre", ticks_wrap, 0);
    step(10);
    check("wrap_ticks0", ticks, 0);
    check("wrap_pulse", ticks_wrap, 1);
    check("wrap_tick", tick, 1);
    step(1);
    check("wrap_gone", ticks_wrap, 0);

    // en low for 7 cycles holds phase
    en = 1'b0;
    step(7);
    en = 1'b1;
    step(8);
    check("en_hold_pre", tick, 0);
    step(1);
    check("en_hold_tick", tick, 1);
    check("en_hold_ticks", ticks, 1);

    // clr at ticks=5
    step(40);
    check("pre_clr_ticks", ticks, 5);
    step(3);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_ticks", ticks, 0);
    check("clr_tick", tick, 0);
    step(9);
    check("clr_pre10", tick, 0);
    step(1);
    check("clr_tick10", tick, 1);
    check("clr_ticks1", ticks, 1);

    // ch0 one-shot P=3
    step(1);
    ch_load[0]     = 1'b1;
    ch_periodic[0] = 1'b0;
    ch_period[7:0] = 8'd3;
    step(1);
    ch_load[0] = 1'b0;
    check("os_busy", ch_busy[0], 1);
    check("os_noexp", ch_expire[0], 0);
    step(28);
    check("os_tick3", tick, 1);
    check("os_exp_early", ch_expire[0], 0);
    check("os_busy_run", ch_busy[0], 1);
    step(1);
    check("os_expire", ch_expire[0], 1);
    check("os_idle", ch_busy[0], 0);
    step(1);
    check("os_exp_pulse", ch_expire[0], 0);

    // ch1 periodic P=2
    ch_load[1]      = 1'b1;
    ch_periodic[1]  = 1'b1;
    ch_period[15:8] = 8'd2;
    step(1);
    ch_load[1] = 1'b0;
    check("per_busy", ch_busy[1], 1);
    step(18);
    check("per_exp1", ch_expire[1], 1);
`ifdef TIMEBASE_PERIODIC_EN
    check("per_busy1", ch_busy[1], 1);
    for (int k = 0; k < 4; k++) begin
      step(19);
      check("per_gap", ch_expire[1], 0);
      step(1);
      check("per_expn", ch_expire[1], 1);
    end
    ch_stop[1] = 1'b1;
    step(1);
    ch_stop[1] = 1'b0;
    check("per_stop", ch_busy[1], 0);
    step(19);
    check("per_noexp", ch_expire[1], 0);
`else
    check("per_as_os", ch_busy[1], 0);
    step(20);
    check("per_os_noexp", ch_expire[1], 0);
    check("per_os_idle", ch_busy[1], 0);
`endif

    // P=0 load
    ch_load[0]     = 1'b1;
    ch_period[7:0] = 8'd0;
    step(1);
    ch_load[0] = 1'b0;
    check("p0_expire", ch_expire[0], 1);
    check("p0_busy", ch_busy[0], 0);
    step(1);
    check("p0_pulse", ch_expire[0], 0);
    check("p0_busy2", ch_busy[0], 0);

    // reload at remain=1 on a tick cycle
    ch_load[0]     = 1'b1;
    ch_period[7:0] = 8'd2;
    step(1);
    ch_load[0] = 1'b0;
    check("rl_busy", ch_busy[0], 1);
    step(16);
    check("rl_tick", tick, 1);
    check("rl_noexp0", ch_expire[0], 0);
    ch_load[0] = 1'b1;
    step(1);
    ch_load[0] = 1'b0;
    check("rl_discard", ch_expire[0], 0);
    check("rl_busy2", ch_busy[0], 1);
    step(19);
    check("rl_tick2", tick, 1);
    check("rl_noexp2", ch_expire[0], 0);
    step(1);
    check("rl_expire", ch_expire[0], 1);
    check("rl_idle", ch_busy[0], 0);

    // async reset mid-count
    ch_load        = 2'b11;
    ch_periodic    = 2'b00;
    ch_period      = {8'd5, 8'd5};
    step(1);
    ch_load = 2'b00;
    check("ar_busy", ch_busy, 2'b11);
    step(8);
    check("ar_tick", tick, 1);
    sys_rst_n = 1'b0;
    #1;
    check("ar_tick0", tick, 0);
    check("ar_ticks0", ticks, 0);
    check("ar_wrap0", ticks_wrap, 0);
    check("ar_busy0", ch_busy, 0);
    check("ar_exp0", ch_expire, 0);
    step(3);
    check("ar_hold", ch_busy, 0);
    sys_rst_n = 1'b1;
    step(60);
    check("ar_noexp", ch_expire, 0);
    check("ar_idle", ch_busy, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
